// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared width helpers for the packed FIFO
package fifo_pkg;

    // Ceiling log2 with a floor of 1 so a depth of 2 still gets a 1-bit pointer.
    function automatic int log2(input int n);
        int bits;
        bits = 1;
        while ((1 << bits) < n) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - depth x elementWidth storage, synchronous write, combinational read
module fifo_mem #(
    parameter int elementWidth = 32,
    parameter int depth        = 64,
    parameter int addrWidth    = 6
) (
    input  logic                    clk,
    input  logic                    i_wr_en,
    input  logic [addrWidth-1:0]    i_wr_addr,
    input  logic [elementWidth-1:0] i_wr_data,
    input  logic [addrWidth-1:0]    i_rd_addr,
    output logic [elementWidth-1:0] o_rd_data
);

    // Storage is intentionally not reset; contents are only meaningful behind count.
    logic [elementWidth-1:0] r_mem [depth];

    // Write port: one entry per accepted push.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_packed.sv
// rtl/fifo_packed.sv - first-word-fall-through FIFO; FIFO_LEVEL_EN adds count/almost_full/high_water
module fifo_packed
    import fifo_pkg::*;
#(
    parameter int elementWidth    = 32,
    parameter int depth           = 64,
    parameter int almostFullLevel = depth - 2,
    parameter int addrWidth       = log2(depth),
    parameter int cntWidth        = log2(depth + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [elementWidth-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [elementWidth-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef FIFO_LEVEL_EN
    ,
    output logic [cntWidth-1:0]     count,
    output logic                    almost_full,
    output logic [cntWidth-1:0]     high_water
`endif
);

    localparam logic [cntWidth-1:0]  DEPTH_CNT = cntWidth'(depth);
    localparam logic [addrWidth-1:0] LAST_ADDR = addrWidth'(depth - 1);

    if (depth < 2 || almostFullLevel < 0 || almostFullLevel > depth) begin : g_param_check
        $error("fifo_packed: depth must be >= 2 and almostFullLevel within 0..depth");
    end

    logic [addrWidth-1:0] r_wr_ptr;
    logic [addrWidth-1:0] r_rd_ptr;
    logic [cntWidth-1:0]  r_count;
    logic [cntWidth-1:0]  w_count_next;
    logic                 w_push;
    logic                 w_pop;

    // Handshake flags come only from registered count and rst, never from the peer's strobes.
    assign in_ready  = (r_count != DEPTH_CNT) && !rst;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Occupancy next-state: simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Pointer and occupancy registers; pointers wrap explicitly so any depth works.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    fifo_mem #(
        .elementWidth (elementWidth),
        .depth        (depth),
        .addrWidth    (addrWidth)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (in_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (out_data)
    );

`ifdef FIFO_LEVEL_EN
    logic [cntWidth-1:0] r_high_water;

    // Peak occupancy since reset, tracking the value count is about to take.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_high_water <= '0;
        end else if (w_count_next > r_high_water) begin
            r_high_water <= w_count_next;
        end
    end

    assign count       = r_count;
    assign almost_full = (r_count >= cntWidth'(almostFullLevel));
    assign high_water  = r_high_water;
`endif

endmodule

// File: tb/tb_fifo_packed.sv
// tb/tb_fifo_packed.sv - directed vector bench for fifo_packed (depth 4, 8-bit, almostFullLevel 3)
module tb_fifo_packed;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
`ifdef FIFO_LEVEL_EN
    logic [2:0]   count;
    logic         almost_full;
    logic [2:0]   high_water;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_packed #(
        .elementWidth    (W),
        .depth           (D),
        .almostFullLevel (AF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FIFO_LEVEL_EN
        ,
        .count       (count),
        .almost_full (almost_full),
        .high_water  (high_water)
`endif
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic       c_od;
        logic [2:0] e_cnt;
        logic       e_af;
        logic [2:0] e_hw;
    } vec_t;

    vec_t tv[24];

    function automatic vec_t mk(input logic r, input logic iv, input logic [7:0] id, input logic ordy,
                                input logic ir, input logic ov, input logic [7:0] od, input logic c_od,
                                input logic [2:0] cnt, input logic af, input logic [2:0] hw);
        vec_t v;
        v.rst = r;  v.iv = iv;  v.id = id;  v.ordy = ordy;
        v.e_ir = ir; v.e_ov = ov; v.e_od = od; v.c_od = c_od;
        v.e_cnt = cnt; v.e_af = af; v.e_hw = hw;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check the outputs of the current state, then take the edge.
    task automatic step(input string tag, input vec_t v);
        rst       = v.rst;
        in_valid  = v.iv;
        in_data   = v.id;
        out_ready = v.ordy;
        #1;
        cmp({tag, " in_ready"},  32'(in_ready),  32'(v.e_ir));
        cmp({tag, " out_valid"}, 32'(out_valid), 32'(v.e_ov));
        if (v.c_od) cmp({tag, " out_data"}, 32'(out_data), 32'(v.e_od));
`ifdef FIFO_LEVEL_EN
        cmp({tag, " count"},       32'(count),       32'(v.e_cnt));
        cmp({tag, " almost_full"}, 32'(almost_full), 32'(v.e_af));
        cmp({tag, " high_water"},  32'(high_water),  32'(v.e_hw));
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fill to full, overflow attempts, drain, then steady push+pop at count 2.
        tv[0]  = mk(1, 0, 8'h00, 0,  0, 0, 8'h00, 0, 0, 0, 0);
        tv[1]  = mk(0, 1, 8'hA1, 0,  1, 0, 8'h00, 0, 0, 0, 0);
        tv[2]  = mk(0, 1, 8'hB2, 0,  1, 1, 8'hA1, 1, 1, 0, 1);
        tv[3]  = mk(0, 1, 8'hC3, 0,  1, 1, 8'hA1, 1, 2, 0, 2);
        tv[4]  = mk(0, 1, 8'hD4, 0,  1, 1, 8'hA1, 1, 3, 1, 3);
        tv[5]  = mk(0, 1, 8'hEE, 0,  0, 1, 8'hA1, 1, 4, 1, 4);
        tv[6]  = mk(0, 1, 8'hEE, 1,  0, 1, 8'hA1, 1, 4, 1, 4);
        tv[7]  = mk(0, 0, 8'h00, 1,  1, 1, 8'hB2, 1, 3, 1, 4);
        tv[8]  = mk(0, 0, 8'h00, 1,  1, 1, 8'hC3, 1, 2, 0, 4);
        tv[9]  = mk(0, 0, 8'h00, 1,  1, 1, 8'hD4, 1, 1, 0, 4);
        tv[10] = mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 0, 0, 4);
        tv[11] = mk(0, 1, 8'h10, 0,  1, 0, 8'h00, 0, 0, 0, 4);
        tv[12] = mk(0, 1, 8'h11, 0,  1, 1, 8'h10, 1, 1, 0, 4);
        for (int k = 0; k < 8; k++) begin
            tv[13 + k] = mk(0, 1, 8'(8'h12 + k), 1,  1, 1, 8'(8'h10 + k), 1, 2, 0, 4);
        end
        tv[21] = mk(0, 0, 8'h00, 1,  1, 1, 8'h18, 1, 2, 0, 4);
        tv[22] = mk(0, 0, 8'h00, 1,  1, 1, 8'h19, 1, 1, 0, 4);
        tv[23] = mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 0, 0, 4);

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            step($sformatf("vec%0d", i), tv[i]);
        end

        // Pops on an empty FIFO are ignored; a push with out_ready high still lands.
        for (int i = 0; i < 3; i++) begin
            step($sformatf("empty_pop%0d", i), mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0, 0, 4));
        end
        step("empty_push",  mk(0, 1, 8'h55, 1,  1, 0, 8'h00, 0, 0, 0, 4));
        step("after_push",  mk(0, 1, 8'h66, 0,  1, 1, 8'h55, 1, 1, 0, 4));
        step("fill_three",  mk(0, 1, 8'h67, 0,  1, 1, 8'h55, 1, 2, 0, 4));

        // Reset with both strobes active discards contents and the peak.
        step("rst_mid",     mk(1, 1, 8'h99, 1,  0, 1, 8'h55, 1, 3, 1, 4));
        step("post_rst",    mk(0, 1, 8'h77, 0,  1, 0, 8'h00, 0, 0, 0, 0));
        step("post_push",   mk(0, 0, 8'h00, 1,  1, 1, 8'h77, 1, 1, 0, 1));
        step("post_drain",  mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 0, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_packed.md
FIFO_PACKED -- requirements
Module: fifo_packed

Interface
REQ-001 SHALL have parameter elementWidth, default 32, data width in bits.
REQ-002 SHALL have parameter depth, default 64, entry count; any integer >= 2.
REQ-003 SHALL have parameter almostFullLevel, default depth-2, occupancy at or above which almost_full asserts.
REQ-004 SHALL have derived parameter addrWidth = log2(depth) and cntWidth = log2(depth+1).
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 in_data  in  elementWidth  write data.
REQ-008 in_valid  in  1  producer offers in_data.
REQ-009 in_ready  out  1  FIFO accepts; equals (count != depth) && !rst.
REQ-010 out_data  out  elementWidth  head entry (first-word-fall-through).
REQ-011 out_valid  out  1  equals (count != 0).
REQ-012 out_ready  in  1  consumer takes head.
REQ-013 count  out  cntWidth  occupancy, registered (FIFO_LEVEL_EN only).
REQ-014 almost_full  out  1  count >= almostFullLevel (FIFO_LEVEL_EN only).
REQ-015 high_water  out  cntWidth  max count since reset (FIFO_LEVEL_EN only).

Function
REQ-016 Push SHALL occur on a clock edge where in_valid && in_ready; pop where out_valid && out_ready.
REQ-017 Data pushed at edge N SHALL be presented on out_data with out_valid=1 from cycle N+1 when FIFO was empty.
REQ-018 Entries SHALL leave in strict push order; no loss, no duplication.
REQ-019 Write and read pointers SHALL advance by 1 per push/pop and wrap from depth-1 to 0; depth need not be a power of two.
REQ-020 Push and pop in the same edge with 0 < count < depth SHALL leave count unchanged and advance both pointers.
REQ-021 When full, in_ready SHALL be 0 irrespective of out_ready (no combinational ready-through); a same-cycle pop frees the slot for the next cycle.
REQ-022 When empty, out_ready SHALL be ignored; a same-cycle push SHALL make count 1.
REQ-023 out_data SHALL be undefined-but-stable while out_valid=0; no output glitch to X required.
REQ-024 Occupancy SHALL never exceed depth nor go below 0.
REQ-025 in_ready, out_valid SHALL depend only on registered state and rst, never on in_valid/out_ready.

Reset
REQ-026 rst high at an edge SHALL set pointers and count to 0; high_water to 0.
REQ-027 During and one cycle after a reset edge out_valid=0; in_ready=0 while rst=1, 1 once rst=0.
REQ-028 Reset asserted mid-operation SHALL discard all contents; pushes/pops at that edge are ignored.
REQ-029 Storage array SHALL not be reset.

Configuration
REQ-030 Macro FIFO_LEVEL_EN defined: count, almost_full, high_water ports and logic present; high_water updates to count's next value when it exceeds current high_water.
REQ-031 FIFO_LEVEL_EN undefined: those three ports absent; internal full/empty tracking unchanged; all other behaviour identical.

Structure
REQ-032 Shared package fifo_pkg SHALL hold the log2 function and any pointer/count width helpers.
REQ-033 Storage SHALL be sub-module fifo_mem: depth x elementWidth array, synchronous write, combinational read by address.

Verification (depth=4, elementWidth=8, almostFullLevel=3, FIFO_LEVEL_EN defined unless stated)
REQ-034 Reset, push 0xA1,0xB2,0xC3,0xD4 with out_ready=0 -> count 1..4, almost_full from count=3, in_ready=0 after 4th, out_data=0xA1.
REQ-035 From full, out_ready=1 for 4 cycles -> out_data 0xA1,0xB2,0xC3,0xD4, then out_valid=0, count=0, high_water=4.
REQ-036 Hold count=2, push+pop every cycle for 10 values 0x10..0x19 -> count stays 2, outputs in order, pointers wrap twice.
REQ-037 Empty FIFO, out_ready=1 with in_valid=0 for 3 cycles -> count 0, out_valid 0; then one push of 0x55 -> out_valid=1, out_data=0x55 next cycle.
REQ-038 count=3, assert rst one cycle with in_valid=out_ready=1 -> count=0, high_water=0, out_valid=0, in_ready=1 after rst falls.
REQ-039 Rebuild without FIFO_LEVEL_EN, rerun REQ-034..REQ-036 data checks -> identical out_data/out_valid/in_ready sequences.
